// File: rtl/mio_responder.sv
// Memory/IO bus responder: decodes CPU loads/stores to RAM, GPIO or timer and
// returns read data with a one-cycle MIO_ready acknowledge after a fixed latency.
module mio_responder #(
   parameter int unsigned RAM_WAIT = 2,
   parameter int unsigned RAM_AW   = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              CPU_MIO,
   input  logic              MemRW,
   input  logic [31:0]       Addr_in,
   input  logic [31:0]       Data_wr,
   output logic [31:0]       Data_rd,
   output logic              MIO_ready,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [31:0]       ram_din,
   output logic              ram_we,
   input  logic [31:0]       ram_dout,
   input  logic [15:0]       sw_in,
   output logic [15:0]       led_out,
   output logic              bus_err
);

   typedef enum logic [1:0] {S_IDLE, S_RWAIT, S_ACK} state_t;
   typedef enum logic [1:0] {R_RAM, R_GPIO, R_TMR, R_NONE} region_t;

   localparam logic [31:0] GPIO_ADDR = 32'hE000_0000;
   localparam logic [31:0] TMR_ADDR  = 32'hF000_0000;
   localparam logic [3:0]  WAIT_INIT = 4'(RAM_WAIT);

   state_t            state, state_nx;
   region_t           req_region, region_q, acc_region;
   logic              rw_q, acc_rw, ack_entry;
   logic [31:0]       data_q, timer;
   logic [RAM_AW-1:0] addr_q;
   logic [3:0]        wait_cnt;

   always_comb begin
      if (Addr_in[31:RAM_AW+2] == '0)
         req_region = R_RAM;
      else if (Addr_in == GPIO_ADDR)
         req_region = R_GPIO;
      else if (Addr_in == TMR_ADDR)
         req_region = R_TMR;
      else
         req_region = R_NONE;
   end

   // IO accesses enter ACK straight from IDLE, so the access being acked is the
   // live request there and the latched one when coming from RWAIT.
   always_comb begin
      state_nx   = state;
      ack_entry  = 1'b0;
      acc_region = region_q;
      acc_rw     = rw_q;
      case (state)
         S_IDLE: begin
            acc_region = req_region;
            acc_rw     = MemRW;
            if (CPU_MIO) begin
               if (req_region == R_RAM) begin
                  state_nx = S_RWAIT;
               end else begin
                  state_nx  = S_ACK;
                  ack_entry = 1'b1;
               end
            end
         end
         S_RWAIT: begin
            if (wait_cnt == 4'd1) begin
               state_nx  = S_ACK;
               ack_entry = 1'b1;
            end
         end
         S_ACK:   state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= S_IDLE;
         region_q <= R_NONE;
         rw_q     <= 1'b0;
         data_q   <= '0;
         addr_q   <= '0;
         wait_cnt <= '0;
         Data_rd  <= '0;
         led_out  <= '0;
         timer    <= '0;
         bus_err  <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == S_IDLE && CPU_MIO) begin
            region_q <= req_region;
            rw_q     <= MemRW;
            data_q   <= Data_wr;
            addr_q   <= Addr_in[RAM_AW+1:2];
            wait_cnt <= WAIT_INIT;
         end else if (state == S_RWAIT) begin
            wait_cnt <= wait_cnt - 4'd1;
         end
         if (ack_entry && !acc_rw) begin
            case (acc_region)
               R_RAM:   Data_rd <= ram_dout;
               R_GPIO:  Data_rd <= {16'h0000, sw_in};
               R_TMR:   Data_rd <= timer;
               default: Data_rd <= '0;
            endcase
         end
         if (ack_entry && acc_region == R_NONE)
            bus_err <= 1'b1;
         if (state == S_ACK && rw_q && region_q == R_GPIO)
            led_out <= data_q[15:0];
         // A timer store overrides the free-running increment.
         if (state == S_ACK && rw_q && region_q == R_TMR)
            timer <= data_q;
         else
            timer <= timer + 32'd1;
      end
   end

   assign MIO_ready = (state == S_ACK);
   assign ram_we    = (state == S_ACK) && rw_q && (region_q == R_RAM);
   assign ram_addr  = addr_q;
   assign ram_din   = data_q;

endmodule

// File: tb/tb_mio_responder.sv
// Randomized self-checking bench for mio_responder against a transaction-level
// reference model (shadow memory, LED/error flags, arithmetic timer).
module tb_mio_responder;

   localparam int unsigned W  = 2;
   localparam int unsigned AW = 10;

   logic          clk = 1'b0, rst = 1'b0, CPU_MIO = 1'b0, MemRW = 1'b0;
   logic [31:0]   Addr_in = '0, Data_wr = '0, Data_rd, ram_din, ram_dout = '0;
   logic          MIO_ready, ram_we, bus_err;
   logic [AW-1:0] ram_addr;
   logic [15:0]   sw_in = '0, led_out;

   mio_responder #(.RAM_WAIT(W), .RAM_AW(AW)) dut (
      .clk(clk), .rst(rst), .CPU_MIO(CPU_MIO), .MemRW(MemRW),
      .Addr_in(Addr_in), .Data_wr(Data_wr), .Data_rd(Data_rd),
      .MIO_ready(MIO_ready), .ram_addr(ram_addr), .ram_din(ram_din),
      .ram_we(ram_we), .ram_dout(ram_dout), .sw_in(sw_in),
      .led_out(led_out), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Board RAM: synchronous read, one cycle latency
   logic [31:0] ram_mem [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (ram_we) ram_mem[ram_addr] <= ram_din;
      ram_dout <= ram_mem[ram_addr];
   end

   int n_tests = 0, n_fail = 0;
   int we_cnt = 0, we_cyc = -1, dbl_rdy = 0, stray_we = 0;
   logic [AW-1:0] we_addr = '0;
   logic prev_rdy = 1'b0;

   always @(negedge clk) begin
      if (ram_we) begin
         we_cnt++;
         we_cyc  = cyc;
         we_addr = ram_addr;
         if (!MIO_ready) stray_we++;
      end
      if (MIO_ready && prev_rdy) dbl_rdy++;
      prev_rdy = MIO_ready;
   end

   // Reference model state
   logic [31:0] mem_ref [0:(1<<AW)-1];
   logic [15:0] led_ref = '0;
   logic        err_ref = 1'b0;
   logic [31:0] tw_val = '0;
   int          tw_cyc = 0;
   int          last_ack = -10;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int region_of(input logic [31:0] a);
      if ((a >> (AW + 2)) == 0) return 0;
      if (a == 32'hE000_0000)   return 1;
      if (a == 32'hF000_0000)   return 2;
      return 3;
   endfunction

   // Called at a negedge; returns at the negedge of the ack cycle with the request still driven.
   task automatic xfer(input logic rw, input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output int ack_c);
      int c0, exp_ack, rg;
      bit got;
      logic [31:0] exp_rd;
      CPU_MIO = 1'b1; MemRW = rw; Addr_in = addr; Data_wr = wd;
      c0 = cyc;
      rg = region_of(addr);
      exp_ack = ((last_ack == c0) ? c0 + 1 : c0) + 1 + ((rg == 0) ? int'(W) : 0);
      got = 0;
      ack_c = -1;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (MIO_ready) begin
            got = 1;
            ack_c = cyc;
         end
      end
      rd = Data_rd;
      check("ack_seen", 32'(got), 32'd1);
      if (!got) begin
         last_ack = cyc;
         return;
      end
      check("ack_cycle", ack_c, exp_ack);
      last_ack = ack_c;
      if (!rw) begin
         case (rg)
            0:       exp_rd = mem_ref[addr[AW+1:2]];
            1:       exp_rd = {16'h0000, sw_in};
            2:       exp_rd = tw_val + 32'(ack_c - tw_cyc - 2);
            default: exp_rd = 32'h0;
         endcase
         check("rd_data", rd, exp_rd);
      end else begin
         case (rg)
            0: mem_ref[addr[AW+1:2]] = wd;
            1: led_ref = wd[15:0];
            2: begin tw_val = wd; tw_cyc = ack_c; end
            default: ;
         endcase
      end
      if (rg == 3) err_ref = 1'b1;
      check("bus_err", bus_err, err_ref);
   endtask

   task automatic idle(input int n);
      CPU_MIO = 1'b0;
      repeat (n) @(negedge clk);
      check("led_out", led_out, led_ref);
   endtask

   task automatic do_reset();
      logic [31:0] rd;
      int a;
      rst = 1'b0; CPU_MIO = 1'b1; MemRW = 1'b0; Addr_in = 32'hE000_0000; sw_in = 16'h3C3C;
      repeat (2) begin
         @(negedge clk);
         check("rst_ready", MIO_ready, 1'b0);
         check("rst_we", ram_we, 1'b0);
      end
      check("rst_data_rd", Data_rd, 32'h0);
      check("rst_led", led_out, 16'h0);
      check("rst_bus_err", bus_err, 1'b0);
      check("rst_ram_addr", ram_addr, '0);
      check("rst_ram_din", ram_din, 32'h0);
      rst = 1'b1;
      led_ref = '0; err_ref = 1'b0; tw_val = '0; tw_cyc = cyc - 1; last_ack = -10;
      xfer(1'b0, 32'hE000_0000, 32'h0, rd, a);
      check("rst_first_rd", rd, 32'h0000_3C3C);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd, rd2, addr, wd;
      int a, a2, we0, rg, gap;
      for (int i = 0; i < (1 << AW); i++) begin
         ram_mem[i] = '0;
         mem_ref[i] = '0;
      end
      @(negedge clk);
      do_reset();
      idle(1);

      we0 = we_cnt;
      xfer(1'b1, 32'h0000_0010, 32'h1234_5678, rd, a);
      idle(1);
      check("ram_we_count", we_cnt - we0, 1);
      check("ram_we_cycle", we_cyc, a);
      check("ram_we_addr", we_addr, 4);
      xfer(1'b0, 32'h0000_0010, 32'h0, rd, a);
      check("ram_rd", rd, 32'h1234_5678);
      idle(1);

      xfer(1'b1, 32'hE000_0000, 32'hABCD_5A5A, rd, a);
      idle(1);
      check("gpio_led", led_out, 16'h5A5A);
      sw_in = 16'h00F0;
      xfer(1'b0, 32'hE000_0000, 32'h0, rd, a);
      check("gpio_rd", rd, 32'h0000_00F0);
      idle(1);

      xfer(1'b1, 32'hF000_0000, 32'hFFFF_FFFE, rd, a);
      xfer(1'b0, 32'hF000_0000, 32'h0, rd, a);
      xfer(1'b0, 32'hF000_0000, 32'h0, rd2, a2);
      check("tmr_write_wins", rd, 32'hFFFF_FFFE);
      check("tmr_wrap", rd2, 32'h0);
      idle(2);

      xfer(1'b0, 32'hE000_0000, 32'h0, rd, a);
      xfer(1'b0, 32'hE000_0000, 32'h0, rd, a2);
      check("b2b_spacing", a2 - a, 2);
      idle(1);

      xfer(1'b0, 32'h8000_0000, 32'h0, rd, a);
      check("unmapped_rd", rd, 32'h0);
      check("unmapped_err", bus_err, 1'b1);
      idle(1);
      we0 = we_cnt;
      xfer(1'b1, 32'h0000_1000, 32'h5555_AAAA, rd, a);
      idle(1);
      check("unmapped_no_we", we_cnt - we0, 0);
      xfer(1'b0, 32'h0000_0010, 32'h0, rd, a);
      check("err_sticky", bus_err, 1'b1);
      idle(1);

      for (int t = 0; t < 200; t++) begin
         rg = $urandom_range(0, 3);
         case (rg)
            0:       addr = 32'($urandom_range(0, 15)) << 2;
            1:       addr = 32'hE000_0000;
            2:       addr = 32'hF000_0000;
            default: addr = ($urandom_range(0, 3) == 0) ? 32'h0000_1000
                            : (32'h8000_0000 | ($urandom & 32'h0FFF_FFFC));
         endcase
         wd = $urandom;
         sw_in = 16'($urandom);
         xfer(1'($urandom_range(0, 1)), addr, wd, rd, a);
         gap = $urandom_range(0, 2);
         if (gap > 0) idle(gap);
      end
      idle(1);

      // Abort an in-flight RAM write with reset
      xfer(1'b1, 32'h0000_0020, 32'h0BAD_F00D, rd, a);
      idle(1);
      we0 = we_cnt;
      CPU_MIO = 1'b1; MemRW = 1'b1; Addr_in = 32'h0000_0020; Data_wr = 32'hDEAD_BEEF;
      @(negedge clk);
      do_reset();
      idle(3);
      check("abort_no_we", we_cnt - we0, 0);
      xfer(1'b0, 32'h0000_0020, 32'h0, rd, a);
      check("abort_ram_kept", rd, 32'h0BAD_F00D);
      idle(1);

      check("no_double_ready", dbl_rdy, 0);
      check("no_stray_we", stray_we, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
